select_sequencer: RTL

SELECT_SEQUENCER -- requirements
Module: select_sequencer

---
 rtl/select_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/select_sequencer.sv
// Steps a registered select index through 0..NUM_STEPS-1, spending DWELL enabled
// cycles on each value, in one-shot hold, wrap or ping-pong order.
module select_sequencer #(
    parameter int SEL_W     = 4,
    parameter int NUM_STEPS = 10,
    parameter int DWELL     = 1562500,
    parameter int CNT_W     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [SEL_W-1:0] select,
    output logic             step_pulse,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       M_HOLD   = 2'd0;
    localparam logic [1:0]       M_WRAP   = 2'd1;
    localparam logic [1:0]       M_PING   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_STEPS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic             dir_up_q;
    logic [1:0]       mode_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    logic [SEL_W-1:0] sel_adv;
    logic             dir_adv;
    logic             hold_end;

    // Value select takes at the end of the current dwell, per latched mode.
    always_comb begin
        sel_adv  = sel_q;
        dir_adv  = dir_up_q;
        hold_end = 1'b0;
        case (mode_q)
            M_WRAP: sel_adv = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_ONE;
            M_PING: begin
                if (NUM_STEPS == 1) begin
                    sel_adv = '0;
                end else if (dir_up_q) begin
                    if (sel_q == SEL_LAST) begin
                        sel_adv = sel_q - SEL_ONE;
                        dir_adv = 1'b0;
                    end else begin
                        sel_adv = sel_q + SEL_ONE;
                    end
                end else begin
                    if (sel_q == '0) begin
                        sel_adv = sel_q + SEL_ONE;
                        dir_adv = 1'b1;
                    end else begin
                        sel_adv = sel_q - SEL_ONE;
                    end
                end
            end
            default: begin
                if (sel_q == SEL_LAST) hold_end = 1'b1;
                else                   sel_adv  = sel_q + SEL_ONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            dir_up_q <= 1'b1;
            mode_q   <= M_HOLD;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (start) begin
                // Start restarts from any state; mode 11 behaves as hold.
                state_q  <= S_RUN;
                cnt_q    <= '0;
                sel_q    <= '0;
                dir_up_q <= 1'b1;
                mode_q   <= (mode == 2'b11) ? M_HOLD : mode;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
            end else if (state_q == S_RUN && enable) begin
                if (cnt_q != CNT_LAST) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else begin
                    cnt_q <= '0;
                    if (hold_end) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        sel_q    <= sel_adv;
                        dir_up_q <= dir_adv;
                        pulse_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign select     = sel_q;
    assign step_pulse = pulse_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule
